// File: rtl/retire_trace_pkg.sv
// Shared types for the retire trace monitor: record layout, kind encoding and FSM states.
// The record is 71 bits, packed MSB first as {inum, kind, pc, reg, value, addr}.
package retire_trace_pkg;

  localparam int INUM_W  = 16;
  localparam int KIND_W  = 3;
  localparam int PC_W    = 16;
  localparam int REG_W   = 4;
  localparam int VALUE_W = 16;
  localparam int ADDR_W  = 16;

  typedef enum logic [KIND_W-1:0] {
    KIND_NOP   = 3'd0,
    KIND_REG   = 3'd1,
    KIND_LOAD  = 3'd2,
    KIND_STORE = 3'd3,
    KIND_HALT  = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  typedef struct packed {
    logic [INUM_W-1:0]  inum;
    kind_e              kind;
    logic [PC_W-1:0]    pc;
    logic [REG_W-1:0]   rd;
    logic [VALUE_W-1:0] value;
    logic [ADDR_W-1:0]  addr;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  // A register write that also reads memory is a load; it outranks halt and store.
  function automatic kind_e classify(input logic reg_write, input logic mem_read,
                                     input logic halt, input logic mem_write);
    if (reg_write && mem_read) return KIND_LOAD;
    if (reg_write)             return KIND_REG;
    if (halt)                  return KIND_HALT;
    if (mem_write)             return KIND_STORE;
    return KIND_NOP;
  endfunction

endpackage

// File: rtl/retire_trace_monitor_fifo.sv
// First-word-fall-through FIFO holding trace records; pointers wrap modulo DEPTH and a
// separate count register tells full from empty.
module trace_fifo #(
  parameter int DATA_W = 71,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_monitor.sv
// Captures one record per retiring cycle while the CPU runs, queues it for the record
// stream, and keeps instruction/cycle statistics, a watchdog and overflow status.
module retire_trace_monitor
  import retire_trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      pc,
  input  logic             reg_write,
  input  logic [3:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data,
  input  logic             halt,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [REC_W-1:0] rec_data,
  output logic [15:0]      inst_count,
  output logic [31:0]      cycle_count,
  output logic             done,
  output logic             timeout,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [15:0]            r_inst_count;
  logic [31:0]            r_cycle_count;
  logic [31:0]            w_cycle_next;
  logic                   r_done;
  logic                   r_overflow;
  logic [7:0]             r_drop_count;
  logic                   w_capture;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  kind_e                  w_kind;
  rec_t                   w_rec;

  assign w_capture    = (r_state == RUN) && en;
  assign w_kind       = classify(reg_write, mem_read, halt, mem_write);
  assign w_cycle_next = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 32'd1;
  assign w_pop        = rec_valid && rec_ready;
  assign w_push       = w_capture && (!w_full || w_pop);
  assign w_drop       = w_capture && w_full && !w_pop;

  always_comb begin
    w_rec      = '0;
    w_rec.inum = r_inst_count;
    w_rec.kind = w_kind;
    w_rec.pc   = pc;
    case (w_kind)
      KIND_REG: begin
        w_rec.rd    = write_reg;
        w_rec.value = write_data;
      end
      KIND_LOAD: begin
        w_rec.rd    = write_reg;
        w_rec.value = write_data;
        w_rec.addr  = mem_addr;
      end
      KIND_STORE: begin
        w_rec.value = mem_data;
        w_rec.addr  = mem_addr;
      end
      default: ;
    endcase
  end

  // Halt is checked before the watchdog so a halt on the limit cycle ends cleanly.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (en) w_next_state = RUN;
      RUN: begin
        if (!en)                                  w_next_state = IDLE;
        else if (w_kind == KIND_HALT)             w_next_state = HALTED;
        else if (w_cycle_next == 32'(CYCLE_LIMIT)) w_next_state = TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_inst_count  <= '0;
      r_cycle_count <= '0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_state <= w_next_state;
      r_done  <= ((r_state == HALTED) || (r_state == TIMEOUT)) && (w_count == '0);
      if (w_capture) begin
        r_inst_count  <= r_inst_count + 16'd1;
        r_cycle_count <= w_cycle_next;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  trace_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (rec_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign rec_valid   = !w_empty;
  assign inst_count  = r_inst_count;
  assign cycle_count = r_cycle_count;
  assign done        = r_done;
  assign timeout     = (r_state == TIMEOUT);
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;

endmodule
